// File: rtl/spi_key_receiver.sv
// SPI mode-0 slave byte receiver feeding a small FIFO toward the keyboard interface.
// SPI pins are asynchronous; everything runs in the clk domain after synchronization.
module spi_key_receiver #(
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       mosi,
   input  logic       sck,
   input  logic       csn,
   output logic [7:0] spi_data,
   output logic       spi_data_ready,
   input  logic       spi_data_ack,
   output logic       overflow,
   output logic       frame_error
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [SYNC_STAGES-1:0] mosi_pipe;
   logic [SYNC_STAGES-1:0] sck_pipe;
   logic [SYNC_STAGES-1:0] csn_pipe;
   logic                   mosi_s;
   logic                   sck_s;
   logic                   csn_s;
   logic                   sck_prev;
   logic                   csn_prev;

   logic                   sck_rise;
   logic                   csn_fall;
   logic                   csn_rise;

   logic [7:0]             shift;
   logic [2:0]             bit_cnt;
   logic [7:0]             new_byte;
   logic                   byte_done;

   logic [7:0]             mem [FIFO_DEPTH];
   logic [PTR_W-1:0]       wr_ptr;
   logic [PTR_W-1:0]       rd_ptr;
   logic [CNT_W-1:0]       count;
   logic                   full;
   logic                   pop;
   logic                   accept;
   logic                   drop;

   // Synchronize all three pins with identical depth so mosi stays aligned to sck.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mosi_pipe <= '0;
         sck_pipe  <= '0;
         csn_pipe  <= '1;
      end else begin
         mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], mosi};
         sck_pipe  <= {sck_pipe[SYNC_STAGES-2:0], sck};
         csn_pipe  <= {csn_pipe[SYNC_STAGES-2:0], csn};
      end
   end

   assign mosi_s = mosi_pipe[SYNC_STAGES-1];
   assign sck_s  = sck_pipe[SYNC_STAGES-1];
   assign csn_s  = csn_pipe[SYNC_STAGES-1];

   // Delayed copies of synchronized sck/csn for edge detection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sck_prev <= 1'b0;
         csn_prev <= 1'b1;
      end else begin
         sck_prev <= sck_s;
         csn_prev <= csn_s;
      end
   end

   // Edge strobes, byte completion and FIFO push/pop decisions.
   always_comb begin
      sck_rise  = sck_s & ~sck_prev;
      csn_fall  = ~csn_s & csn_prev;
      csn_rise  = csn_s & ~csn_prev;
      new_byte  = {shift[6:0], mosi_s};
      byte_done = ~csn_s & ~csn_fall & sck_rise & (bit_cnt == 3'd7);
      full      = (count == CNT_W'(FIFO_DEPTH));
      pop       = spi_data_ack & spi_data_ready;
      accept    = byte_done & (~full | pop);
      drop      = byte_done & full & ~pop;
   end

   // Shift register and bit counter; csn edges frame the byte stream.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shift       <= '0;
         bit_cnt     <= '0;
         frame_error <= 1'b0;
      end else begin
         frame_error <= 1'b0;
         if (csn_fall) begin
            bit_cnt <= '0;
         end else if (csn_rise) begin
            if (bit_cnt != 3'd0) begin
               frame_error <= 1'b1;
            end
            bit_cnt <= '0;
            shift   <= '0;
         end else if (~csn_s && sck_rise) begin
            shift   <= new_byte;
            bit_cnt <= bit_cnt + 3'd1;
         end
      end
   end

   // Byte FIFO; a full FIFO drops the new byte unless the head is popped the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            mem[i] <= '0;
         end
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         overflow <= drop;
         if (accept) begin
            mem[wr_ptr] <= new_byte;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (accept && !pop) begin
            count <= count + CNT_W'(1);
         end else if (pop && !accept) begin
            count <= count - CNT_W'(1);
         end
      end
   end

   assign spi_data       = mem[rd_ptr];
   assign spi_data_ready = (count != '0);

endmodule

// File: tb/tb_spi_key_receiver.sv
// Self-checking bench for spi_key_receiver: directed scenarios plus random bytes
// checked against a queue-based model of the FIFO contents and event counts.
module tb_spi_key_receiver;

   localparam int unsigned DEPTH = 4;

   logic       clk;
   logic       reset;
   logic       mosi;
   logic       sck;
   logic       csn;
   logic [7:0] spi_data;
   logic       spi_data_ready;
   logic       spi_data_ack;
   logic       overflow;
   logic       frame_error;

   int         total;
   int         bad;
   int         ovf_seen;
   int         ferr_seen;
   int         exp_ovf;
   int         exp_ferr;
   logic [7:0] model_q[$];

   spi_key_receiver #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
      .clk            (clk),
      .reset          (reset),
      .mosi           (mosi),
      .sck            (sck),
      .csn            (csn),
      .spi_data       (spi_data),
      .spi_data_ready (spi_data_ready),
      .spi_data_ack   (spi_data_ack),
      .overflow       (overflow),
      .frame_error    (frame_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count cycles in which each pulse output is high.
   always @(negedge clk) begin
      if (overflow)    ovf_seen  <= ovf_seen + 1;
      if (frame_error) ferr_seen <= ferr_seen + 1;
   end

   task automatic wait_clk(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic frame_start();
      csn = 1'b0;
      wait_clk(4);
   endtask

   task automatic frame_end();
      csn = 1'b1;
      wait_clk(6);
   endtask

   // Send the top n bits of v, MSB first, mode 0 timing.
   task automatic send_bits(input logic [7:0] v, input int n);
      for (int i = 0; i < n; i++) begin
         mosi = v[3'(7 - i)];
         wait_clk(2);
         sck = 1'b1;
         wait_clk(4);
         sck = 1'b0;
         wait_clk(2);
      end
   endtask

   // Full byte; samples ready around the push edge and optionally acks exactly on it.
   task automatic send_byte(input logic [7:0] v, input bit ack_on_push,
                            output logic rdy_before, output logic rdy_after,
                            output logic [7:0] data_after);
      send_bits(v, 7);
      mosi = v[0];
      wait_clk(2);
      sck = 1'b1;
      wait_clk(2);
      rdy_before = spi_data_ready;
      if (ack_on_push) spi_data_ack = 1'b1;
      wait_clk(1);
      spi_data_ack = 1'b0;
      rdy_after  = spi_data_ready;
      data_after = spi_data;
      wait_clk(1);
      sck = 1'b0;
      wait_clk(2);
      if (ack_on_push && model_q.size() > 0) void'(model_q.pop_front());
      if (model_q.size() < DEPTH) model_q.push_back(v);
      else exp_ovf++;
   endtask

   task automatic drain(input string tag);
      while (model_q.size() > 0) begin
         chk({tag, "_ready"}, 32'(spi_data_ready), 32'(1));
         chk({tag, "_data"}, 32'(spi_data), 32'(model_q[0]));
         spi_data_ack = 1'b1;
         wait_clk(1);
         spi_data_ack = 1'b0;
         void'(model_q.pop_front());
      end
      chk({tag, "_empty"}, 32'(spi_data_ready), 32'(0));
   endtask

   initial begin
      logic       rb;
      logic       ra;
      logic [7:0] da;
      logic [7:0] b;
      bit         a;

      total = 0; bad = 0; ovf_seen = 0; ferr_seen = 0; exp_ovf = 0; exp_ferr = 0;
      mosi = 1'b0; sck = 1'b0; csn = 1'b1; spi_data_ack = 1'b0; reset = 1'b1;
      wait_clk(3);
      chk("rst_ready", 32'(spi_data_ready), 32'(0));
      chk("rst_data", 32'(spi_data), 32'(0));
      chk("rst_ovf", 32'(overflow), 32'(0));
      chk("rst_ferr", 32'(frame_error), 32'(0));
      reset = 1'b0;
      wait_clk(3);

      // Ack on an empty FIFO is ignored.
      spi_data_ack = 1'b1;
      wait_clk(1);
      spi_data_ack = 1'b0;
      chk("empty_ack", 32'(spi_data_ready), 32'(0));

      // Single byte with latency check.
      frame_start();
      send_byte(8'h41, 1'b0, rb, ra, da);
      chk("lat_before", 32'(rb), 32'(0));
      chk("lat_after", 32'(ra), 32'(1));
      chk("lat_data", 32'(da), 32'(8'h41));
      frame_end();
      drain("single");

      // Burst in one frame.
      frame_start();
      send_byte(8'h08, 1'b0, rb, ra, da);
      send_byte(8'h0D, 1'b0, rb, ra, da);
      send_byte(8'h61, 1'b0, rb, ra, da);
      frame_end();
      chk("burst_ready", 32'(spi_data_ready), 32'(1));
      drain("burst");

      // Overflow on the fifth byte.
      frame_start();
      for (int i = 0; i < 5; i++) send_byte(8'(8'h30 + i), 1'b0, rb, ra, da);
      frame_end();
      chk("ovf_count", 32'(ovf_seen), 32'(exp_ovf));
      chk("ovf_exp_one", 32'(exp_ovf), 32'(1));
      drain("ovf");

      // Full FIFO with ack on the push cycle: no overflow.
      frame_start();
      for (int i = 0; i < 4; i++) send_byte(8'(8'h30 + i), 1'b0, rb, ra, da);
      send_byte(8'h34, 1'b1, rb, ra, da);
      frame_end();
      chk("ackfull_ovf", 32'(ovf_seen), 32'(exp_ovf));
      drain("ackfull");

      // Partial byte then csn high, then a clean frame.
      frame_start();
      send_bits(8'hA5, 5);
      frame_end();
      exp_ferr++;
      chk("ferr_count", 32'(ferr_seen), 32'(exp_ferr));
      chk("ferr_fifo", 32'(spi_data_ready), 32'(0));
      frame_start();
      send_byte(8'h7E, 1'b0, rb, ra, da);
      frame_end();
      chk("ferr_ovf", 32'(ovf_seen), 32'(exp_ovf));
      drain("after_ferr");

      // Reset mid-byte with a byte already buffered.
      frame_start();
      send_byte(8'h99, 1'b0, rb, ra, da);
      send_bits(8'hFF, 3);
      chk("mid_ready", 32'(spi_data_ready), 32'(1));
      reset = 1'b1;
      csn = 1'b1;
      wait_clk(2);
      chk("mid_rst_ready", 32'(spi_data_ready), 32'(0));
      chk("mid_rst_data", 32'(spi_data), 32'(0));
      chk("mid_rst_ovf", 32'(overflow), 32'(0));
      chk("mid_rst_ferr", 32'(frame_error), 32'(0));
      model_q.delete();
      reset = 1'b0;
      wait_clk(4);
      chk("post_rst_ready", 32'(spi_data_ready), 32'(0));
      frame_start();
      send_byte(8'h5A, 1'b0, rb, ra, da);
      frame_end();
      chk("post_rst_ferr", 32'(ferr_seen), 32'(exp_ferr));
      drain("post_rst");

      // Random bytes with random acks on the push cycle and random drains.
      frame_start();
      for (int i = 0; i < 16; i++) begin
         b = 8'($urandom);
         a = ($urandom_range(0, 3) == 0);
         send_byte(b, a, rb, ra, da);
         if ($urandom_range(0, 3) == 0) drain("rnd_mid");
      end
      frame_end();
      chk("rnd_ovf", 32'(ovf_seen), 32'(exp_ovf));
      chk("rnd_ferr", 32'(ferr_seen), 32'(exp_ferr));
      drain("rnd_end");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
